// File: rtl/ray_intake.sv
// Ray intake: tracks the ray generator's handshake in lockstep and buffers rays in a FWFT FIFO.
// Latency: ready_internal at cycle t -> val_dir and FIFO write at t+2; head visible the cycle after the write.
// Backpressure: a request is only raised while the FIFO has a free slot, so a capture is never dropped.
module ray_intake #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [12:0]        image_width,
  input  logic [12:0]        image_height,
  input  logic [2:0]         core_number,
  input  logic [1:0]         op_code,
  input  logic signed [11:0] ray_dir_x,
  input  logic signed [11:0] ray_dir_y,
  input  logic signed [11:0] ray_dir_z,
  input  logic signed [31:0] loop_index,
  output logic               ready_internal,
  output logic               val_dir,
  output logic               ray_out_valid,
  input  logic               ray_out_ready,
  output logic signed [11:0] ray_out_x,
  output logic signed [11:0] ray_out_y,
  output logic signed [11:0] ray_out_z,
  output logic signed [31:0] ray_out_index,
  output logic               busy,
  output logic               done,
  output logic               seq_error
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int DW = 3 * 12 + 32;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SYNC0   = 3'd1,
    S_SYNC1   = 3'd2,
    S_REQ     = 3'd3,
    S_WAIT    = 3'd4,
    S_CAPTURE = 3'd5,
    S_ADVANCE = 3'd6
  } state_t;

  state_t              state_q, state_d;
  logic signed [31:0]  exp_q, exp_d;
  logic [2:0]          stride_q, stride_d;
  logic                done_q, done_d;
  logic                seq_err_q, seq_err_d;
  logic                val_dir_q;

  logic [DW-1:0]       mem_q [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]       cnt_q;

  logic                start, push, pop, advance, last;
  logic [25:0]         area;
  logic signed [31:0]  limit;
  logic [DW-1:0]       head;

  // Last pixel of this core: old expected index beyond (pixels - stride), signed 32-bit
  assign area  = {13'd0, image_width} * {13'd0, image_height};
  assign limit = $signed({6'd0, area}) - $signed({29'd0, stride_q});
  assign last  = (exp_q > limit);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic mirroring the generator's sequence
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (en) state_d = S_SYNC0;
      S_SYNC0:   state_d = S_SYNC1;
      S_SYNC1:   state_d = S_REQ;
      S_REQ:     if (ready_internal) state_d = S_WAIT;
      S_WAIT:    state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_ADVANCE;
      S_ADVANCE: state_d = last ? S_IDLE : S_REQ;
      default:   state_d = S_IDLE;
    endcase
  end

  // State-decoded controls; the request reserves the slot the capture will fill
  always_comb begin
    ready_internal = 1'b0;
    busy           = 1'b1;
    start          = 1'b0;
    push           = 1'b0;
    advance        = 1'b0;
    unique case (state_q)
      S_IDLE:    begin busy = 1'b0; start = en; end
      S_REQ:     ready_internal = (cnt_q < CW'(FIFO_DEPTH));
      S_CAPTURE: push = 1'b1;
      S_ADVANCE: advance = 1'b1;
      default:   ;
    endcase
  end

  // Frame bookkeeping: expected index, stride and sticky flags
  always_comb begin
    exp_d     = exp_q;
    stride_d  = stride_q;
    done_d    = done_q;
    seq_err_d = seq_err_q;
    if (start) begin
      exp_d     = {29'd0, core_number};
      stride_d  = {1'b0, op_code} + 3'd1;
      done_d    = 1'b0;
      seq_err_d = 1'b0;
    end
    if (push && (loop_index != exp_q)) seq_err_d = 1'b1;
    if (advance) begin
      exp_d = exp_q + $signed({29'd0, stride_q});
      if (last) done_d = 1'b1;
    end
  end

  // Bookkeeping registers; val_dir is registered from the upcoming state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_q     <= '0;
      stride_q  <= 3'd1;
      done_q    <= 1'b0;
      seq_err_q <= 1'b0;
      val_dir_q <= 1'b0;
    end else begin
      exp_q     <= exp_d;
      stride_q  <= stride_d;
      done_q    <= done_d;
      seq_err_q <= seq_err_d;
      val_dir_q <= (state_d == S_CAPTURE);
    end
  end

  assign val_dir   = val_dir_q;
  assign done      = done_q;
  assign seq_error = seq_err_q;

  // FIFO storage; contents need no reset because outputs are gated by occupancy
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {ray_dir_x, ray_dir_y, ray_dir_z, loop_index};
  end

  assign pop = ray_out_valid && ray_out_ready;

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push && !pop)      cnt_q <= cnt_q + CW'(1);
      else if (pop && !push) cnt_q <= cnt_q - CW'(1);
    end
  end

  assign ray_out_valid = (cnt_q != '0);
  assign head          = ray_out_valid ? mem_q[rd_ptr_q] : '0;
  assign {ray_out_x, ray_out_y, ray_out_z, ray_out_index} = head;

endmodule

// File: tb/tb_ray_intake.sv
module tb_ray_intake;
  localparam int DEPTH = 4;

  logic               clk = 1'b0;
  logic               rst, en;
  logic [12:0]        w, h;
  logic [2:0]         core;
  logic [1:0]         op;
  logic signed [11:0] dx, dy, dz;
  logic signed [31:0] li;
  logic               ready_internal, val_dir, ray_out_valid, ordy;
  logic signed [11:0] ray_out_x, ray_out_y, ray_out_z;
  logic signed [31:0] ray_out_index;
  logic               busy, done, seq_error;

  ray_intake #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(rst), .en(en),
    .image_width(w), .image_height(h), .core_number(core), .op_code(op),
    .ray_dir_x(dx), .ray_dir_y(dy), .ray_dir_z(dz), .loop_index(li),
    .ready_internal(ready_internal), .val_dir(val_dir),
    .ray_out_valid(ray_out_valid), .ray_out_ready(ordy),
    .ray_out_x(ray_out_x), .ray_out_y(ray_out_y), .ray_out_z(ray_out_z),
    .ray_out_index(ray_out_index),
    .busy(busy), .done(done), .seq_error(seq_error)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [67:0] q[$];        // rays the DUT should be holding, oldest first
  int gen_list[$];          // indices the generator model will hand out
  int exp_idx[$];           // indices expected at the output, in order
  int out_idx[$];           // indices actually popped
  int checks = 0, errors = 0;
  int cyc = 0, last_req = -100, caps = 0, reqs = 0, extra = 0;
  bit rnd = 0, ordy_set = 0;

  task automatic chk(input string tag, input logic [67:0] obs, input logic [67:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Index sequence straight from the frame rules: capture, stop once index > pixels - stride
  function automatic void build(int total, int c, int s, bit corr);
    int e = c;
    exp_idx.delete(); gen_list.delete();
    for (int k = 0; k < 10000; k++) begin
      int v = (corr && e == 4) ? 5 : e;
      exp_idx.push_back(v);
      gen_list.push_back(v);
      if (e > total - s) break;
      e += s;
    end
  endfunction

  // One clock: at the falling edge drive ready, check outputs, update the model, answer requests
  task automatic tick();
    int occ0;
    @(negedge clk);
    cyc++;
    ordy = rnd ? 1'($urandom_range(0, 1)) : ordy_set;
    if (!rst) begin
      occ0 = q.size();
      chk("val_dir_latency", val_dir, 68'(cyc == last_req + 2));
      chk("out_valid", ray_out_valid, 68'(occ0 != 0));
      if (ray_out_valid && occ0 != 0) begin
        chk("head_entry", {ray_out_x, ray_out_y, ray_out_z, ray_out_index}, q[0]);
        if (ordy) begin
          out_idx.push_back(int'(q[0][31:0]));
          void'(q.pop_front());
        end
      end
      if (val_dir) begin
        q.push_back({dx, dy, dz, li});
        caps++;
      end
      if (ready_internal) begin
        chk("req_spacing", 68'((cyc - last_req) >= 4), 68'(1));
        chk("req_room", 68'(occ0 < DEPTH), 68'(1));
        last_req = cyc;
        reqs++;
        dx = 12'($urandom); dy = 12'($urandom); dz = 12'($urandom);
        if (gen_list.size() != 0) li = gen_list.pop_front();
        else begin li = 32'hBAD0BAD0; extra++; end
      end
    end
  endtask

  task automatic start_frame(input int wv, input int hv, input int cv, input int ov, input bit corr);
    w = 13'(wv); h = 13'(hv); core = 3'(cv); op = 2'(ov);
    build(wv * hv, cv, ov + 1, corr);
    out_idx.delete(); extra = 0;
    en = 1'b1;
    tick();
    en = 1'b0;
    chk("start_done_clear", done, 0);
    chk("start_seq_clear", seq_error, 0);
    chk("start_busy", busy, 1);
  endtask

  task automatic finish_frame(input bit corr);
    int n = 0;
    rnd = 1;
    while (done !== 1'b1 && n < 3000) begin tick(); n++; end
    chk("done_reached", done, 1);
    chk("idle_busy", busy, 0);
    chk("idle_no_req", ready_internal, 0);
    rnd = 0; ordy_set = 1; n = 0;
    while (q.size() != 0 && n < 100) begin tick(); n++; end
    tick();
    ordy_set = 0;
    chk("drained", ray_out_valid, 0);
    chk("done_sticky", done, 1);
    chk("out_count", out_idx.size(), exp_idx.size());
    for (int i = 0; i < exp_idx.size() && i < out_idx.size(); i++)
      chk("out_order", out_idx[i], exp_idx[i]);
    chk("requests_used", gen_list.size() + extra, 0);
    chk("seq_error", seq_error, 68'(corr));
  endtask

  initial begin
    int n, rq, c0;
    rst = 1'b1; en = 1'b0; ordy = 1'b0;
    w = '0; h = '0; core = '0; op = '0;
    dx = '0; dy = '0; dz = '0; li = '0;
    #1;
    chk("rst_ready", ready_internal, 0);
    chk("rst_val_dir", val_dir, 0);
    chk("rst_valid", ray_out_valid, 0);
    chk("rst_flags", {busy, done, seq_error}, 0);
    chk("rst_data", {ray_out_x, ray_out_y, ray_out_z, ray_out_index}, 0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // 4x2, one core; a stray en mid-frame must be ignored
    start_frame(4, 2, 0, 0, 0);
    repeat (6) tick();
    en = 1'b1; tick(); en = 1'b0;
    finish_frame(0);

    // 4x2, two cores, this is core 1
    start_frame(4, 2, 1, 1, 0);
    finish_frame(0);

    // Generator hands out 5 where 4 is expected
    start_frame(4, 2, 0, 0, 1);
    finish_frame(1);

    // Zero-pixel frame still makes one request
    start_frame(0, 3, 0, 0, 0);
    finish_frame(0);

    // Full FIFO stalls requests; one pop frees exactly one request
    start_frame(6, 4, 0, 0, 0);
    rnd = 0; ordy_set = 0;
    repeat (40) tick();
    chk("fill_captures", caps >= 0 ? 68'(q.size()) : 68'(0), 68'(DEPTH));
    rq = reqs;
    repeat (20) tick();
    chk("stall_no_req", 68'(reqs - rq), 68'(0));
    chk("stall_ready_low", ready_internal, 0);
    ordy_set = 1; tick();
    ordy_set = 0; tick();
    chk("req_after_pop", 68'(last_req), 68'(cyc));
    // Occupancy is 3 with a capture pending: pop in the capture cycle
    tick();
    ordy_set = 1; tick();
    chk("push_pop_capture", val_dir, 1);
    ordy_set = 0;
    c0 = caps;
    repeat (30) tick();
    chk("push_pop_occupancy", 68'(caps - c0), 68'(1));
    finish_frame(0);

    // Random frames exercise pointer wrap under random backpressure
    for (int f = 0; f < 3; f++) begin
      start_frame($urandom_range(1, 6), $urandom_range(1, 4), $urandom_range(0, 7),
                  $urandom_range(0, 3), 0);
      finish_frame(0);
    end

    // Reset while capturing with two rays already buffered
    start_frame(4, 2, 0, 0, 0);
    rnd = 0; ordy_set = 0; n = 0;
    while (!(val_dir && q.size() == 3) && n < 200) begin tick(); n++; end
    chk("reached_capture", 68'(n < 200), 68'(1));
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", ready_internal, 0);
    chk("mid_rst_val_dir", val_dir, 0);
    chk("mid_rst_valid", ray_out_valid, 0);
    chk("mid_rst_flags", {busy, done, seq_error}, 0);
    chk("mid_rst_data", {ray_out_x, ray_out_y, ray_out_z, ray_out_index}, 0);
    q.delete(); gen_list.delete(); last_req = -100;
    tick();
    rst = 1'b0;
    tick();
    start_frame(4, 2, 3, 3, 0);
    finish_frame(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
